// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Sits between EX/MEM and MEM/WB. It issues one request/grant/response bus
// transaction per load or store, applies RV32I byte/half/word lane handling,
// and holds the upstream pipeline with stall_M while an access is in flight.
//
// Optional feature: define MEM_TIMEOUT_EN to add a bus watchdog. When the
// watchdog expires, the access is aborted and bus_err_M is flagged for one
// cycle. Without the macro, the FSM waits indefinitely and bus_err_M is 0.
//
// Handshake: dmem_req is held high until the bus returns dmem_gnt, and the
// request is accepted in the cycle where both are high. Loads then wait in
// RESP for a single dmem_rvalid pulse, whose dmem_rdata is captured. rvalid and
// gnt are ignored in any state that does not expect them.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] write_data_M,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3_M,
  output logic [31:0] read_data_M,
  output logic        stall_M,
  output logic        misalign_M,
  output logic        bus_err_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;

  logic        op;
  logic        is_load;
  logic        is_store;
  logic        fault;
  logic        req_ok;
  logic        tmo;
  logic        abort;
  logic [1:0]  b;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  // A load wins when both the read and write controls are raised.
  assign op       = MemReadM | MemWriteM;
  assign is_load  = MemReadM;
  assign is_store = MemWriteM & ~MemReadM;
  assign b        = ALUResult_M[1:0];

  // Decode misaligned half/word addresses and the unused funct3 encodings.
  always_comb begin
    fault = 1'b0;
    case (funct3_M)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = ALUResult_M[0];
      3'b010:         fault = |ALUResult_M[1:0];
      default:        fault = 1'b1;
    endcase
  end

  assign req_ok = op & ~fault;

  // Select the addressed lane of the read word and extend it to 32 bits.
  always_comb begin
    ld_byte = 8'h00;
    case (b)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = ALUResult_M[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_ext  = dmem_rdata;
    case (funct3_M)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // Replicate the store data across lanes and form the byte enables.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = write_data_M;
    case (funct3_M[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << b;
        st_wdata = {4{write_data_M[7:0]}};
      end
      2'b01: begin
        st_strb  = ALUResult_M[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{write_data_M[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = write_data_M;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;
  logic          counting;

  // The watchdog only runs while waiting on the bus (grant or response).
  assign counting = ((state_q == IDLE) & req_ok) | (state_q == RESP);
  assign tmo      = counting & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count wait cycles; restart whenever the FSM changes state.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && counting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter and the one-cycle abort flag shown in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= abort;
    end
  end

  assign bus_err_M = (state_q == DONE) & err_q;
`else
  // Watchdog compiled out: tmo is constant 0 (TIMEOUT_CYCLES is never negative).
  assign tmo       = (TIMEOUT_CYCLES < 0);
  assign bus_err_M = 1'b0;
`endif

  // Abort only when the expected bus event did not arrive in the expiry cycle.
  assign abort = tmo & (((state_q == IDLE) & ~dmem_gnt) |
                        ((state_q == RESP) & ~dmem_rvalid));

  // State and captured-load-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; data_q is cleared on stores and aborts so DONE shows 0.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          if (dmem_gnt) begin
            state_d = is_load ? RESP : DONE;
            data_d  = 32'h0;
          end else if (abort) begin
            state_d = DONE;
            data_d  = 32'h0;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_d = DONE;
          data_d  = ld_ext;
        end else if (abort) begin
          state_d = DONE;
          data_d  = 32'h0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and pipeline outputs; all forced low while reset is asserted.
  always_comb begin
    dmem_req    = reset & (state_q == IDLE) & req_ok;
    dmem_we     = dmem_req & is_store;
    dmem_wstrb  = dmem_we ? st_strb : 4'b0000;
    dmem_wdata  = dmem_we ? st_wdata : 32'h0;
    dmem_addr   = {ALUResult_M[31:2], 2'b00};
    stall_M     = reset & (((state_q == IDLE) & req_ok) | (state_q == RESP));
    misalign_M  = reset & (state_q == IDLE) & op & fault;
    read_data_M = (reset & (state_q == DONE)) ? data_q : 32'h0;
    fsm_state_o = state_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic [31:0] ALUResult_M;
  logic [31:0] write_data_M;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3_M;
  logic [31:0] read_data_M;
  logic        stall_M;
  logic        misalign_M;
  logic        bus_err_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  fsm_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ALUResult_M  (ALUResult_M),
    .write_data_M (write_data_M),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .funct3_M     (funct3_M),
    .read_data_M  (read_data_M),
    .stall_M      (stall_M),
    .misalign_M   (misalign_M),
    .bus_err_M    (bus_err_M),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .fsm_state_o  (fsm_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drop the op and spend one idle cycle.
  task automatic idle_cycle();
    @(negedge clk);
    MemReadM    = 1'b0;
    MemWriteM   = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    #1;
    check("idle_req", {31'b0, dmem_req}, 32'h0);
  endtask

  // Load: grant after gnt_wait cycles, rvalid rv_wait cycles after the grant cycle+1.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int gnt_wait,
                         input int rv_wait, input logic [31:0] exp);
    @(negedge clk);
    ALUResult_M = addr;
    funct3_M    = f3;
    MemReadM    = 1'b1;
    dmem_gnt    = 1'b0;
    for (int i = 0; i < gnt_wait; i++) begin
      #1;
      check("ld_wait_req", {31'b0, dmem_req}, 32'h1);
      check("ld_wait_stall", {31'b0, stall_M}, 32'h1);
      @(negedge clk);
    end
    dmem_gnt = 1'b1;
    #1;
    check("ld_req", {31'b0, dmem_req}, 32'h1);
    check("ld_we", {31'b0, dmem_we}, 32'h0);
    check("ld_stall", {31'b0, stall_M}, 32'h1);
    check("ld_addr", dmem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    dmem_gnt = 1'b0;
    for (int i = 0; i < rv_wait; i++) begin
      #1;
      check("ld_resp_stall", {31'b0, stall_M}, 32'h1);
      @(negedge clk);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    check("ld_resp_state", {30'b0, fsm_state_o}, {30'b0, S_RESP});
    check("ld_resp_req", {31'b0, dmem_req}, 32'h0);
    check("ld_resp_stall", {31'b0, stall_M}, 32'h1);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    #1;
    check("ld_done_state", {30'b0, fsm_state_o}, {30'b0, S_DONE});
    check("ld_done_stall", {31'b0, stall_M}, 32'h0);
    check("ld_data", read_data_M, exp);
    MemReadM = 1'b0;
  endtask

  // Store: grant after gnt_wait cycles of request.
  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data, input int gnt_wait,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    @(negedge clk);
    ALUResult_M  = addr;
    funct3_M     = f3;
    write_data_M = data;
    MemWriteM    = 1'b1;
    dmem_gnt     = 1'b0;
    for (int i = 0; i <= gnt_wait; i++) begin
      if (i == gnt_wait) dmem_gnt = 1'b1;
      #1;
      check("st_req", {31'b0, dmem_req}, 32'h1);
      check("st_we", {31'b0, dmem_we}, 32'h1);
      check("st_stall", {31'b0, stall_M}, 32'h1);
      check("st_strb", {28'b0, dmem_wstrb}, {28'b0, exp_strb});
      check("st_wdata", dmem_wdata, exp_wdata);
      check("st_addr", dmem_addr, {addr[31:2], 2'b00});
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    #1;
    check("st_done_state", {30'b0, fsm_state_o}, {30'b0, S_DONE});
    check("st_done_stall", {31'b0, stall_M}, 32'h0);
    check("st_done_req", {31'b0, dmem_req}, 32'h0);
    check("st_done_data", read_data_M, 32'h0);
    MemWriteM = 1'b0;
  endtask

  // Faulting access: flagged in the same cycle, no request, no stall.
  task automatic do_fault(input logic [31:0] addr, input logic [2:0] f3, input logic wr);
    @(negedge clk);
    ALUResult_M = addr;
    funct3_M    = f3;
    MemReadM    = ~wr;
    MemWriteM   = wr;
    dmem_gnt    = 1'b1;
    #1;
    check("flt_misalign", {31'b0, misalign_M}, 32'h1);
    check("flt_req", {31'b0, dmem_req}, 32'h0);
    check("flt_stall", {31'b0, stall_M}, 32'h0);
    check("flt_data", read_data_M, 32'h0);
    @(negedge clk);
    #1;
    check("flt_state", {30'b0, fsm_state_o}, {30'b0, S_IDLE});
    check("flt_req2", {31'b0, dmem_req}, 32'h0);
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    dmem_gnt  = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    ALUResult_M  = 32'h0;
    write_data_M = 32'h0;
    MemReadM     = 1'b0;
    MemWriteM    = 1'b0;
    funct3_M     = 3'b010;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", {30'b0, fsm_state_o}, {30'b0, S_IDLE});
    check("rst_req", {31'b0, dmem_req}, 32'h0);
    check("rst_data", read_data_M, 32'h0);
    check("rst_err", {31'b0, bus_err_M}, 32'h0);
    reset = 1'b1;
    idle_cycle();

    // Loads
    do_load(32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
    idle_cycle();
    do_load(32'h0000_0103, 3'b000, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80);
    idle_cycle();
    do_load(32'h0000_0103, 3'b100, 32'h80FF_1234, 0, 0, 32'h0000_0080);
    idle_cycle();
    do_load(32'h0000_0102, 3'b001, 32'h80FF_1234, 1, 2, 32'hFFFF_80FF);
    idle_cycle();
    do_load(32'h0000_0100, 3'b101, 32'h80FF_9234, 0, 1, 32'h0000_9234);
    idle_cycle();
    do_load(32'h0000_0101, 3'b000, 32'h0000_7F00, 0, 0, 32'h0000_007F);
    idle_cycle();
    // Read and write both raised: behaves as a load, we stays low.
    MemWriteM = 1'b1;
    do_load(32'h0000_0108, 3'b010, 32'h1357_9BDF, 0, 0, 32'h1357_9BDF);
    MemWriteM = 1'b0;
    idle_cycle();

    // Stores
    do_store(32'h0000_0202, 3'b001, 32'h0000_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
    idle_cycle();
    do_store(32'h0000_0201, 3'b000, 32'h1234_565A, 0, 4'b0010, 32'h5A5A_5A5A);
    idle_cycle();
    do_store(32'h0000_0300, 3'b010, 32'h1234_5678, 1, 4'b1111, 32'h1234_5678);
    idle_cycle();
    do_store(32'h0000_0300, 3'b001, 32'hFFFF_00EE, 0, 4'b0011, 32'h00EE_00EE);
    idle_cycle();

    // Faults
    do_fault(32'h0000_0101, 3'b010, 1'b0);
    do_fault(32'h0000_0203, 3'b001, 1'b1);
    do_fault(32'h0000_0200, 3'b011, 1'b0);
    do_fault(32'h0000_0200, 3'b110, 1'b0);
    idle_cycle();

    // Reset while in RESP
    @(negedge clk);
    ALUResult_M = 32'h0000_0400;
    funct3_M    = 3'b010;
    MemReadM    = 1'b1;
    dmem_gnt    = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check("rr_state", {30'b0, fsm_state_o}, {30'b0, S_RESP});
    reset = 1'b0;
    #1;
    check("rr_state0", {30'b0, fsm_state_o}, {30'b0, S_IDLE});
    check("rr_req0", {31'b0, dmem_req}, 32'h0);
    check("rr_stall0", {31'b0, stall_M}, 32'h0);
    check("rr_data0", read_data_M, 32'h0);
    @(negedge clk);
    MemReadM = 1'b0;
    reset    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("rr_late_state", {30'b0, fsm_state_o}, {30'b0, S_IDLE});
    check("rr_late_data", read_data_M, 32'h0);
    do_load(32'h0000_0400, 3'b010, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D);
    idle_cycle();

    // Watchdog behaviour
    @(negedge clk);
    ALUResult_M = 32'h0000_0500;
    funct3_M    = 3'b010;
    MemReadM    = 1'b1;
    dmem_gnt    = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
`ifdef MEM_TIMEOUT_EN
    // Grant was cycle 0; RESP occupies cycles 1..16, DONE is cycle 17.
    for (int i = 1; i <= 16; i++) begin
      #1;
      check("wd_stall", {31'b0, stall_M}, 32'h1);
      check("wd_err_lo", {31'b0, bus_err_M}, 32'h0);
      @(negedge clk);
    end
    #1;
    check("wd_done_state", {30'b0, fsm_state_o}, {30'b0, S_DONE});
    check("wd_err", {31'b0, bus_err_M}, 32'h1);
    check("wd_data", read_data_M, 32'h0);
    check("wd_stall_lo", {31'b0, stall_M}, 32'h0);
    MemReadM = 1'b0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    #1;
    check("wd_err_clr", {31'b0, bus_err_M}, 32'h0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("wd_late_state", {30'b0, fsm_state_o}, {30'b0, S_IDLE});
    check("wd_late_data", read_data_M, 32'h0);
`else
    // No watchdog: still waiting after 20 silent cycles, then completes.
    for (int i = 0; i < 20; i++) begin
      #1;
      check("nw_stall", {31'b0, stall_M}, 32'h1);
      check("nw_err", {31'b0, bus_err_M}, 32'h0);
      @(negedge clk);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("nw_done_state", {30'b0, fsm_state_o}, {30'b0, S_DONE});
    check("nw_data", read_data_M, 32'h1111_2222);
    check("nw_err_done", {31'b0, bus_err_M}, 32'h0);
    MemReadM = 1'b0;
`endif
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "time bound exceeded");
  end

endmodule
